bus_hex_uart_tx: RTL
====================

# bus_hex_uart_tx

Serial transmitter for the CPU's 32-bit `bus` output, so the board can be observed from a host terminal in addition to the LEDs. It watches `bus` every cycle, and whenever the value changes it sends the newest value over a UART TX line as uppercase ASCII hex, followed by a terminator. It sits beside the `cpu` instance at the top level, consuming `bus` the way the testbench currently probes it.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `CLKS_PER_BIT`, default CLK_HZ/BAUD (integer division): cycles per bit. Must be ≥ 2.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `bus` input, 32 bits: CPU bus value, synchronous to `clk`.
- `tx` output, 1 bit: UART line, 8N1, idle high. Registered.
- `busy` output, 1 bit: high while a message is on the line. Registered.

## Operation
- Capture register `cur` (32 bits) and `pending` flag.
  - Each cycle where `bus != cur`: load `cur <= bus` and set `pending <= 1`.
  - Reset values: `cur = 0`, `pending = 1`, so the value on `bus` at reset release is always sent once.
- Message register `msg` (32 bits) holds the word being sent.
  - When the FSM is in IDLE with `pending = 1`: load `msg <= cur` and clear `pending`.
  - If `bus` changes in that same cycle, the set wins: `pending` stays 1 and `cur` takes the new value.
- Values that arrive during a transmission overwrite `cur`. Intermediate values are dropped; only the newest is sent next.
- Character sequence:
  - `msg[31:28]` first, down to `msg[3:0]`.
  - Nibble n maps to 0x30+n for n ≤ 9, and 0x41+(n−10) for n ≥ 10.
  - Followed by the terminator (see Configuration).
- Each byte is sent as a frame: start bit (0), 8 data bits LSB first, stop bit (1).
- FSM states: IDLE, START, DATA, STOP. Counters: baud counter 0..CLKS_PER_BIT−1, bit index 0..7, char index 0..NCHARS−1.
  - IDLE→START on pending.
  - START→DATA after one bit time.
  - DATA→STOP after 8 bit times.
  - STOP→START (char index+1) if more characters remain.
  - STOP→IDLE after the last character.
- Reset asserted at any point, including mid-bit: asynchronously forces IDLE, `tx = 1`, `busy = 0`, all counters 0, `cur = 0`, `pending = 1`.

## Timing
- Reset values: `tx = 1`, `busy = 0`.
- IDLE with `pending` at edge N:
  - `tx` falls and `busy` rises after edge N+1.
  - No other latency applies.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- There is no idle gap between characters: a stop bit is followed directly by the next start bit.
- Message length is NCHARS×10×CLKS_PER_BIT cycles. `busy` is high for exactly that long.
- `busy` falls in the same cycle the final stop bit ends.
- If `pending` is already set, the next message's start bit begins one cycle later (IDLE is passed through in one cycle).
- `bus` is sampled every cycle and has no setup requirement beyond synchronous timing.

## Configuration
- `BUS_TX_CRLF_EN` defined: NCHARS = 10. The terminator is CR (0x0D) followed by LF (0x0A).
- `BUS_TX_CRLF_EN` undefined: NCHARS = 9. The terminator is a single space (0x20), so values stream on one line.

## Test plan
All scenarios use `CLK_HZ = 16` and `BAUD = 1` (CLKS_PER_BIT = 16). `BUS_TX_CRLF_EN` is defined unless stated.
- **Reset release with `bus = 0`:** required response is the bytes 0x30×8, 0x0D, 0x0A. Each bit is 16 cycles; `busy` is high for 1600 cycles; `tx` falls 1 cycle after the first IDLE edge.
- **`bus = 0x1234ABCD` after idle:** required bytes are 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A. The bench checks each bit LSB first at mid-bit.
- **`bus` changes to 0x1 then 0x2 mid-message:** the next message is "00000002\r\n"; 0x1 is never sent. That message's start bit begins 1 cycle after `busy` falls.
- **Reset asserted mid-data-bit:** `tx = 1` and `busy = 0` immediately, without waiting for a clock edge. After release, the current `bus` value is sent in full.
- **`bus` held stable after a message:** no further frames are sent; `tx` stays 1 and `busy` stays 0 for 5000 cycles.
- **`BUS_TX_CRLF_EN` undefined, `bus = 0xFFFFFFFF`:** required bytes are 0x46×8 then 0x20; `busy` is high for 1440 cycles.

Source files
------------

// File: rtl/bus_hex_uart_tx.sv
// bus_hex_uart_tx
// Streams the CPU bus value to a host terminal as uppercase ASCII hex over an
// 8N1 UART line. Whenever `bus` changes, the newest value is queued and sent
// once the line is free; intermediate values seen during a message are dropped.
//
// Build option:
//   BUS_TX_CRLF_EN defined   -> 10 characters per message, terminator CR LF
//   BUS_TX_CRLF_EN undefined -> 9 characters per message, terminator space
//
// Output timing: tx and busy are registered from the FSM state, so the line
// lags the state by one cycle. Each bit is CLKS_PER_BIT cycles. Characters
// follow each other without an idle gap.
module bus_hex_uart_tx #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] bus,
   output logic        tx,
   output logic        busy
);

`ifdef BUS_TX_CRLF_EN
   localparam int NCHARS = 10;
`else
   localparam int NCHARS = 9;
`endif

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       CHAR_LAST = 4'(NCHARS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [3:0]       char_idx;
   logic [31:0]      msg;

   logic [31:0]      cur;
   logic             pending;

   logic             take;
   logic             bit_end;
   logic [3:0]       nib;
   logic [7:0]       chr;

   // A queued value is accepted only from IDLE; the message FSM copies cur.
   assign take    = (state == IDLE) && pending;
   assign bit_end = (baud_cnt == CNT_LAST);

   // Track the newest bus value; a change in the same cycle as a take keeps
   // the request alive so the fresh value is not lost.
   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur     <= 32'h0;
         pending <= 1'b1;
      end else if (bus != cur) begin
         cur     <= bus;
         pending <= 1'b1;
      end else if (take) begin
         pending <= 1'b0;
      end
   end

   // Select the character for the current char index and map it to ASCII.
   // NOTE: defaults first so every path assigns and no latch is inferred.
   always_comb begin
      nib = 4'h0;
      chr = 8'h20;
      case (char_idx[2:0])
         3'd0:    nib = msg[31:28];
         3'd1:    nib = msg[27:24];
         3'd2:    nib = msg[23:20];
         3'd3:    nib = msg[19:16];
         3'd4:    nib = msg[15:12];
         3'd5:    nib = msg[11:8];
         3'd6:    nib = msg[7:4];
         default: nib = msg[3:0];
      endcase
      if (char_idx < 4'd8) begin
         // 'A' is 0x41, so nibble 10..15 maps to 0x37 + n.
         chr = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else begin
`ifdef BUS_TX_CRLF_EN
         chr = (char_idx == 4'd8) ? 8'h0D : 8'h0A;
`else
         chr = 8'h20;
`endif
      end
   end

   // Message FSM: frames each character as start, 8 data bits LSB first, stop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         char_idx <= 4'd0;
         msg      <= 32'h0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         busy <= (state != IDLE);
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pending) begin
                  msg      <= cur;
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  char_idx <= 4'd0;
                  state    <= START;
               end
            end

            START: begin
               tx <= 1'b0;
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               tx <= chr[bit_idx];
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (char_idx == CHAR_LAST) begin
                     char_idx <= 4'd0;
                     state    <= IDLE;
                  end else begin
                     char_idx <= char_idx + 1'b1;
                     state    <= START;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
